id_operand_stage: RTL
=====================

Name: id_operand_stage

Overview:
- ID-stage operand resolver and ID/EX pipeline register that sits directly downstream of the register-file read ports.
- Takes raw RF read data for rs/rt and applies bypass from EX, MEM and WB; the RF write lands at posedge, so a same-cycle WB write must be bypassed.
- Tracks in-flight long-latency writers (load, mul/div) in a per-register scoreboard.
- Stalls ID on unresolved hazards and hands resolved operands to EX over a valid/ready handshake.

Parameters:
- CTRL_W, 16, width of the opaque decoded-control payload carried ID->EX.
- SB_CNT_W, 2, width of each per-register scoreboard counter; it saturates at 2**SB_CNT_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (`RstEnable)
- flush  in  1  squash ID instruction and ID/EX register (branch/exception redirect)
- ID_valid  in  1  instruction present in ID
- ID_ready  out  1  ID may advance this cycle
- ID_rs, ID_rt  in  5  source register numbers (also drive RF read addresses)
- ID_rs_used, ID_rt_used  in  1  source actually read
- ID_BusA, ID_BusB  in  32  RF read data
- ID_Dst  in  5  destination register
- ID_RegWr  in  1  instruction writes Dst
- ID_Long  in  1  writer is long-latency (load / HI-LO / mul-div)
- ID_Ctrl  in  CTRL_W  decoded control payload
- EX_Dst, MEM_Dst  in  5  destination of instruction in EX / MEM
- EX_RegWr, MEM_RegWr  in  1  that instruction writes
- EX_ResVld, MEM_ResVld  in  1  its result is available this cycle
- EX_Res, MEM_Res  in  32  its result
- WB_Dst  in  5  RF write address (same net as RF)
- WB_RFWr  in  1  RF write enable
- WB_Result  in  32  RF write data
- WB_Long  in  1  the WB write retires a long-latency writer
- EX_valid  out  1  ID/EX register holds an instruction
- EX_ready  in  1  EX accepts this cycle
- EX_OpA, EX_OpB  out  32  resolved operands
- EX_OutDst  out  5  registered Dst
- EX_OutRegWr, EX_OutLong  out  1  registered flags
- EX_OutCtrl  out  CTRL_W  registered payload

Behaviour:
- Reset: EX_valid=0, EX_OpA/OpB/OutDst/OutCtrl=0, EX_OutRegWr/OutLong=0, all scoreboard counters=0. Reset mid-operation discards everything, with no drain.
- Per source s (rs or rt), evaluated only if s_used and s!=0; register 0 always resolves to 32'h0 and never stalls.
- Resolution priority: ID/EX register > EX > MEM > WB > RF.
  - ID/EX register: EX_valid & EX_OutRegWr & EX_OutDst==s gives a hazard (one bubble for back-to-back dependence).
  - EX, then MEM: RegWr & Dst==s. If ResVld, forward Res; otherwise hazard.
  - WB: WB_RFWr & WB_Dst==s forwards WB_Result.
  - RF: if scoreboard[s]!=0 with no match above, hazard; otherwise use ID_Bus.
- Write-after-write guard: ID_RegWr & ID_Long & ID_Dst!=0 & scoreboard[ID_Dst] at max gives a hazard.
- ID_ready = !hazard & (!EX_valid | EX_ready) & !flush.
- ID/EX register loads on ID_valid & ID_ready, capturing resolved operands and the Dst/RegWr/Long/Ctrl fields.
- EX_valid next:
  - flush: 0.
  - load: 1.
  - EX_ready with no load: 0.
  - otherwise hold. Outputs stay stable while EX_valid & !EX_ready.
- Scoreboard increment: EX_valid & EX_ready & !flush & EX_OutRegWr & EX_OutLong & EX_OutDst!=0 increments scoreboard[EX_OutDst]. A flushed ID/EX entry never increments.
- Scoreboard decrement: WB_RFWr & WB_Long & WB_Dst!=0 decrements scoreboard[WB_Dst]. A decrement at 0 is ignored (no underflow).
- Simultaneous increment and decrement of the same register leaves the count unchanged.
- Latency: one cycle ID->EX when no hazard.

Optional Feature:
- Macro: ID_STALL_CNT_EN.
- Defined: adds output stall_cnt (32 bit). It increments each cycle ID_valid & !ID_ready & !flush, wraps at 2^32, and resets to 0.
- Undefined: the port and the counter are absent.

Decomposition:
- Shared package cpu_pkg: typedef reg_idx_t (5 bit), word_t (32 bit), operand-source enum {SRC_ZERO, SRC_EX, SRC_MEM, SRC_WB, SRC_RF}.
- Sub-module fwd_select: combinational per-operand resolver returning data plus hazard. Instantiated twice (rs, rt).

Test Plan:
- RF r5=0x11; ID rs=5, no producers in flight -> next cycle EX_OpA=0x11, EX_valid=1.
- EX_Dst=5, EX_RegWr=1, EX_ResVld=1, EX_Res=0xA5A5 while RF r5=0x11 -> EX_OpA=0xA5A5; MEM_Dst=5 with 0x22 present simultaneously is ignored (EX wins).
- WB writes r7=0xDEAD in the same cycle ID reads rt=7 (RF still returns the old value) -> EX_OpB=0xDEAD.
- Issue long writer to r9, accept into EX, retire it two stages later; dependent ID rs=9 -> ID_ready=0 until WB_Long & WB_Dst=9; cycle after retirement (RF path) OpA correct, scoreboard[9]=0.
- EX_valid=1, EX_ready=0 for 3 cycles -> outputs constant, ID_ready=0; then flush=1 -> EX_valid=0, scoreboard unchanged.
- Dependent back-to-back (ID/EX Dst=3, ID rs=3) -> exactly one bubble. rs=0 with EX_Dst=0 writing -> OpA=0, no stall.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register/word types and operand-source encoding for the ID stage
package cpu_pkg;
    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;
    typedef enum logic [2:0] {SRC_ZERO, SRC_EX, SRC_MEM, SRC_WB, SRC_RF} src_e;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: resolves one source operand through ID/EX, EX, MEM, WB and RF, flagging hazards
module fwd_select
    import cpu_pkg::*;
(
    input  logic     used,
    input  reg_idx_t s,
    input  word_t    bus,
    input  logic     idex_valid,
    input  logic     idex_regwr,
    input  reg_idx_t idex_dst,
    input  logic     ex_regwr,
    input  reg_idx_t ex_dst,
    input  logic     ex_resvld,
    input  word_t    ex_res,
    input  logic     mem_regwr,
    input  reg_idx_t mem_dst,
    input  logic     mem_resvld,
    input  word_t    mem_res,
    input  logic     wb_wr,
    input  reg_idx_t wb_dst,
    input  word_t    wb_res,
    input  logic     sb_busy,
    output word_t    data,
    output logic     hazard
);
    src_e src;
    logic en, idex_hit;
    always_comb begin
        en = used && s != '0;
        idex_hit = idex_valid && idex_regwr && idex_dst == s;
        src = !en ? SRC_ZERO :
              (ex_regwr && ex_dst == s) ? SRC_EX :
              (mem_regwr && mem_dst == s) ? SRC_MEM :
              (wb_wr && wb_dst == s) ? SRC_WB : SRC_RF;
        hazard = en && (idex_hit || (src == SRC_EX && !ex_resvld) ||
                 (src == SRC_MEM && !mem_resvld) || (src == SRC_RF && sb_busy));
        data = src == SRC_EX ? ex_res :
               src == SRC_MEM ? mem_res :
               src == SRC_WB ? wb_res :
               src == SRC_RF ? bus : '0;
    end
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: operand bypass, long-latency scoreboard and ID/EX register (ID_STALL_CNT_EN adds stall_cnt)
module id_operand_stage
    import cpu_pkg::*;
#(
    parameter int CTRL_W   = 16,
    parameter int SB_CNT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ID_valid,
    output logic              ID_ready,
    input  reg_idx_t          ID_rs,
    input  reg_idx_t          ID_rt,
    input  logic              ID_rs_used,
    input  logic              ID_rt_used,
    input  word_t             ID_BusA,
    input  word_t             ID_BusB,
    input  reg_idx_t          ID_Dst,
    input  logic              ID_RegWr,
    input  logic              ID_Long,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    input  reg_idx_t          EX_Dst,
    input  reg_idx_t          MEM_Dst,
    input  logic              EX_RegWr,
    input  logic              MEM_RegWr,
    input  logic              EX_ResVld,
    input  logic              MEM_ResVld,
    input  word_t             EX_Res,
    input  word_t             MEM_Res,
    input  reg_idx_t          WB_Dst,
    input  logic              WB_RFWr,
    input  word_t             WB_Result,
    input  logic              WB_Long,
    output logic              EX_valid,
    input  logic              EX_ready,
    output word_t             EX_OpA,
    output word_t             EX_OpB,
    output reg_idx_t          EX_OutDst,
    output logic              EX_OutRegWr,
    output logic              EX_OutLong,
`ifdef ID_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic [CTRL_W-1:0] EX_OutCtrl
);
    localparam logic [SB_CNT_W-1:0] SB_MAX = {SB_CNT_W{1'b1}};
    logic [SB_CNT_W-1:0] sb [32];
    word_t op_a, op_b;
    logic haz_a, haz_b, waw, load, inc, dec;
    fwd_select u_fwd_a (
        .used(ID_rs_used), .s(ID_rs), .bus(ID_BusA),
        .idex_valid(EX_valid), .idex_regwr(EX_OutRegWr), .idex_dst(EX_OutDst),
        .ex_regwr(EX_RegWr), .ex_dst(EX_Dst), .ex_resvld(EX_ResVld), .ex_res(EX_Res),
        .mem_regwr(MEM_RegWr), .mem_dst(MEM_Dst), .mem_resvld(MEM_ResVld), .mem_res(MEM_Res),
        .wb_wr(WB_RFWr), .wb_dst(WB_Dst), .wb_res(WB_Result),
        .sb_busy(sb[ID_rs] != '0), .data(op_a), .hazard(haz_a)
    );
    fwd_select u_fwd_b (
        .used(ID_rt_used), .s(ID_rt), .bus(ID_BusB),
        .idex_valid(EX_valid), .idex_regwr(EX_OutRegWr), .idex_dst(EX_OutDst),
        .ex_regwr(EX_RegWr), .ex_dst(EX_Dst), .ex_resvld(EX_ResVld), .ex_res(EX_Res),
        .mem_regwr(MEM_RegWr), .mem_dst(MEM_Dst), .mem_resvld(MEM_ResVld), .mem_res(MEM_Res),
        .wb_wr(WB_RFWr), .wb_dst(WB_Dst), .wb_res(WB_Result),
        .sb_busy(sb[ID_rt] != '0), .data(op_b), .hazard(haz_b)
    );
    always_comb begin
        waw = ID_RegWr && ID_Long && ID_Dst != '0 && sb[ID_Dst] == SB_MAX;
        ID_ready = !(haz_a || haz_b || waw) && (!EX_valid || EX_ready) && !flush;
        load = ID_valid && ID_ready;
        inc = EX_valid && EX_ready && !flush && EX_OutRegWr && EX_OutLong && EX_OutDst != '0;
        dec = WB_RFWr && WB_Long && WB_Dst != '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            EX_valid <= 1'b0;
            EX_OpA <= '0;
            EX_OpB <= '0;
            EX_OutDst <= '0;
            EX_OutRegWr <= 1'b0;
            EX_OutLong <= 1'b0;
            EX_OutCtrl <= '0;
        end else begin
            EX_valid <= flush ? 1'b0 : load ? 1'b1 : EX_ready ? 1'b0 : EX_valid;
            if (load) begin
                EX_OpA <= op_a;
                EX_OpB <= op_b;
                EX_OutDst <= ID_Dst;
                EX_OutRegWr <= ID_RegWr;
                EX_OutLong <= ID_Long;
                EX_OutCtrl <= ID_Ctrl;
            end
        end
    end
    // coincident issue and retire of the same register cancel out
    for (genvar g = 0; g < 32; g++) begin : g_sb
        logic up, dn;
        assign up = inc && EX_OutDst == reg_idx_t'(g);
        assign dn = dec && WB_Dst == reg_idx_t'(g);
        always_ff @(posedge clk) begin
            if (rst) sb[g] <= '0;
            else if (up && !dn && sb[g] != SB_MAX) sb[g] <= sb[g] + SB_CNT_W'(1);
            else if (dn && !up && sb[g] != '0) sb[g] <= sb[g] - SB_CNT_W'(1);
        end
    end
`ifdef ID_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) stall_cnt <= '0;
        else if (ID_valid && !ID_ready && !flush) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule
